// File: rtl/ysyx_23060096_imm_encoder_if.sv
// Request/response bus of the immediate encoder: request side (in_*) and
// encoded-instruction side (out_*), each with its own valid/ready handshake.
interface ysyx_23060096_imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_extop;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport slave (
        input  in_valid, in_extop, in_imm, in_base, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );

    modport master (
        output in_valid, in_extop, in_imm, in_base, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/ysyx_23060096_imm_encoder.sv
// Streaming RV32 immediate encoder: scatters an immediate into a base instruction
// word per ExtOP format, flags unrepresentable immediates, buffers E stage + 2-deep FIFO.
module ysyx_23060096_imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    ysyx_23060096_imm_encoder_if.slave bus,
    output logic [15:0] err_cnt
);

    // True when all bits selected by mask carry the same value (sign-extension holds).
    function automatic logic f_sext_ok(input logic [31:0] v, input logic [31:0] mask);
        return ((v & mask) == mask) || ((v & mask) == 32'h0);
    endfunction

    // Returns {err, inst}; the truncated encoding is produced even when err is set.
    function automatic logic [32:0] f_encode(input logic [2:0]  op,
                                             input logic [31:0] imm,
                                             input logic [31:0] base);
        logic [31:0] inst;
        logic        err;
        inst = base;
        err  = 1'b0;
        case (op)
            3'b001: begin
                inst[31:12] = imm[31:12];
                err         = |imm[11:0];
            end
            3'b010: begin
                inst[31:25] = imm[11:5];
                inst[11:7]  = imm[4:0];
                err         = !f_sext_ok(imm, 32'hFFFF_F800);
            end
            3'b011: begin
                inst[31]    = imm[12];
                inst[30:25] = imm[10:5];
                inst[11:8]  = imm[4:1];
                inst[7]     = imm[11];
                err         = imm[0] || !f_sext_ok(imm, 32'hFFFF_F000);
            end
            3'b100: begin
                inst[31]    = imm[20];
                inst[30:21] = imm[10:1];
                inst[20]    = imm[11];
                inst[19:12] = imm[19:12];
                err         = imm[0] || !f_sext_ok(imm, 32'hFFF0_0000);
            end
            default: begin
                // Reserved codes fall back to the I layout but are always flagged.
                inst[31:20] = imm[11:0];
                err         = (op != 3'b000) || !f_sext_ok(imm, 32'hFFFF_F800);
            end
        endcase
        return {err, inst};
    endfunction

    logic [32:0] w_enc;
    logic        w_accept;
    logic        w_pop;
    logic        w_push;
    logic        w_out_valid;

    logic        r_vld_p0;
    logic [31:0] r_inst_p0;
    logic        r_err_p0;

    logic [31:0] r_inst_p1 [2];
    logic [1:0]  r_err_p1;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_cnt;
    logic [15:0] r_err_cnt;

    assign w_enc       = f_encode(bus.in_extop, bus.in_imm, bus.in_base);
    assign w_out_valid = (r_cnt != 2'd0);
    assign w_pop       = w_out_valid && bus.out_ready;
    // E always drains on an accepting edge, so a full FIFO is the only stall.
    assign bus.in_ready = (r_cnt != 2'd2) || w_pop;
    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_push      = r_vld_p0 && ((r_cnt != 2'd2) || w_pop);

    assign bus.out_valid = w_out_valid;
    assign bus.out_inst  = w_out_valid ? r_inst_p1[r_rd_ptr] : 32'h0;
    assign bus.out_err   = w_out_valid ? r_err_p1[r_rd_ptr]  : 1'b0;
    assign err_cnt       = r_err_cnt;

    // ---- stage E (p0) / FIFO (p1) control ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_cnt     <= 2'd0;
            r_err_cnt <= 16'h0;
        end else begin
            if (w_accept) begin
                r_vld_p0 <= 1'b1;
            end else if (w_push) begin
                r_vld_p0 <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_accept && w_enc[32] && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    // ---- stage E (p0) / FIFO (p1) data ----
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_inst_p0 <= w_enc[31:0];
            r_err_p0  <= w_enc[32];
        end
        if (w_push) begin
            r_inst_p1[r_wr_ptr] <= r_inst_p0;
            r_err_p1[r_wr_ptr]  <= r_err_p0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_imm_encoder.sv
// Self-checking bench for the immediate encoder: directed vectors, backpressure,
// randomized streaming against a field-mask reference model, and mid-run reset.
module tb_ysyx_23060096_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] err_cnt;

    ysyx_23060096_imm_encoder_if bus ();

    ysyx_23060096_imm_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int m_err_cnt;

    logic [31:0] q_inst [$];
    logic        q_err  [$];
    logic [31:0] q_imm  [$];
    logic [2:0]  q_op   [$];

    // Reference model: field placement as masks and shifts, legality as signed ranges.
    function automatic logic [31:0] ref_inst(input logic [2:0] op, input logic [31:0] imm,
                                             input logic [31:0] base);
        logic [31:0] mask;
        logic [31:0] field;
        case (op)
            3'd1: begin mask = 32'hFFFFF000; field = imm & 32'hFFFFF000; end
            3'd2: begin
                mask  = 32'hFE000F80;
                field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            end
            3'd3: begin
                mask  = 32'hFE000F80;
                field = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                        (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            end
            3'd4: begin
                mask  = 32'hFFFFF000;
                field = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                        (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
            end
            default: begin mask = 32'hFFF00000; field = imm << 20; end
        endcase
        return (base & ~mask) | field;
    endfunction

    function automatic logic ref_err(input logic [2:0] op, input logic [31:0] imm);
        int s;
        s = imm;
        case (op)
            3'd0, 3'd2: return (s < -2048) || (s > 2047);
            3'd1:       return imm[11:0] != 12'h0;
            3'd3:       return imm[0] || (s < -4096) || (s > 4095);
            3'd4:       return imm[0] || (s < -(1 << 20)) || (s > (1 << 20) - 1);
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_decode(input logic [2:0] op, input logic [31:0] i);
        case (op)
            3'd1:    return {i[31:12], 12'h0};
            3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] imm,
                         input logic [31:0] base);
        bus.in_valid = v;
        bus.in_extop = op;
        bus.in_imm   = imm;
        bus.in_base  = base;
    endtask

    task automatic gen_req(output logic [2:0] op, output logic [31:0] imm,
                           output logic [31:0] base);
        logic [31:0] t;
        logic [31:0] edges [9];
        edges = '{32'd2047, 32'hFFFFF800, 32'd2048, 32'd4094, 32'hFFFFF000,
                  32'd4096, 32'h000FFFFE, 32'hFFF00000, 32'h00100000};
        op   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        base = $urandom;
        t    = $urandom;
        case ($urandom_range(0, 4))
            0: imm = $urandom;
            1: begin imm = {{20{t[11]}}, t[11:0]}; if (t[31]) imm[0] = 1'b0; end
            2: imm = {{12{t[19]}}, t[19:0]} & 32'hFFFFFFFE;
            3: imm = $urandom & 32'hFFFFF000;
            default: imm = edges[$urandom_range(0, 8)];
        endcase
    endtask

    // Record a request the DUT is accepting this cycle (called away from the clock edge).
    task automatic note_accept();
        q_inst.push_back(ref_inst(bus.in_extop, bus.in_imm, bus.in_base));
        q_err.push_back(ref_err(bus.in_extop, bus.in_imm));
        q_imm.push_back(bus.in_imm);
        q_op.push_back(bus.in_extop);
        if (ref_err(bus.in_extop, bus.in_imm) && m_err_cnt != 16'hFFFF) m_err_cnt++;
    endtask

    task automatic clear_model();
        q_inst.delete();
        q_err.delete();
        q_imm.delete();
        q_op.delete();
        m_err_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        bus.out_ready = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_tests++;
        if (bus.out_inst !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_inst: got %h want 00000000", bus.out_inst);
        end
        n_tests++;
        if (bus.out_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_err: got %b want 0", bus.out_err);
        end
        n_tests++;
        if (err_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    logic [2:0]  d_op   [9] = '{3'd0, 3'd3, 3'd3, 3'd4, 3'd1, 3'd1, 3'd2, 3'd5, 3'd0};
    logic [31:0] d_base [9] = '{32'h93, 32'h63, 32'h63, 32'hEF, 32'h37, 32'h37,
                                32'h2023, 32'h13, 32'h93};
    logic [31:0] d_imm  [9] = '{32'hFFFFFFFF, 32'h8, 32'h9, 32'h800, 32'h12345000,
                                32'h12345001, 32'hFFFFFFFC, 32'h5, 32'h800};
    logic [31:0] d_exp  [9] = '{32'hFFF00093, 32'h00000463, 32'h00000463, 32'h001000EF,
                                32'h12345037, 32'h12345037, 32'hFE002E23, 32'h00500013,
                                32'h80000093};
    logic        d_err  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic test_directed();
        int exp_cnt;
        exp_cnt = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            drive(1'b1, d_op[i], d_imm[i], d_base[i]);
            @(negedge clk);
            n_tests++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL dir%0d_in_ready: got %b want 1", i, bus.in_ready);
            end
            if (d_err[i]) exp_cnt++;
            @(posedge clk); #1;
            drive(1'b0, 3'd0, 32'h0, 32'h0);
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_latency: out_valid %b one cycle after accept, want 0", i, bus.out_valid);
            end
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL dir%0d_out_valid: got %b want 1", i, bus.out_valid);
            end
            n_tests++;
            if (bus.out_inst !== d_exp[i]) begin
                n_fail++; $display("FAIL dir%0d_inst: got %h want %h", i, bus.out_inst, d_exp[i]);
            end
            n_tests++;
            if (bus.out_err !== d_err[i]) begin
                n_fail++; $display("FAIL dir%0d_err: got %b want %b", i, bus.out_err, d_err[i]);
            end
            n_tests++;
            if (err_cnt !== 16'(exp_cnt)) begin
                n_fail++; $display("FAIL dir%0d_err_cnt: got %0d want %0d", i, err_cnt, exp_cnt);
            end
        end
        m_err_cnt = exp_cnt;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [2:0]  op   [4];
        logic [31:0] imm  [4];
        logic [31:0] base [4];
        int idx, got, accept_pos;
        logic [31:0] head;
        bit fired;
        for (int i = 0; i < 4; i++) gen_req(op[i], imm[i], base[i]);
        bus.out_ready = 1'b0;
        idx = 0;
        drive(1'b1, op[0], imm[0], base[0]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
            if (fired) note_accept();
            @(posedge clk); #1;
            if (fired) begin
                idx++;
                if (idx < 4) drive(1'b1, op[idx], imm[idx], base[idx]);
                else drive(1'b0, 3'd0, 32'h0, 32'h0);
            end
        end
        @(negedge clk);
        n_tests++;
        if (idx != 3) begin
            n_fail++; $display("FAIL bp_accepted: got %0d want 3", idx);
        end
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready);
        end
        head = bus.out_inst;
        n_tests++;
        if (bus.out_valid !== 1'b1 || head !== q_inst[0]) begin
            n_fail++; $display("FAIL bp_head: valid %b inst %h want 1 %h", bus.out_valid, head, q_inst[0]);
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_inst !== head) begin
            n_fail++; $display("FAIL bp_stable: got %h want %h", bus.out_inst, head);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        got = 0;
        accept_pos = -1;
        for (int c = 0; c < 12 && got < 4; c++) begin
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                if (q_inst.size() == 0 || bus.out_inst !== q_inst[0] || bus.out_err !== q_err[0]) begin
                    n_fail++;
                    $display("FAIL bp_out%0d: got %h/%b want %h/%b", got, bus.out_inst, bus.out_err,
                             (q_inst.size() != 0) ? q_inst[0] : 32'h0, (q_err.size() != 0) ? q_err[0] : 1'b0);
                end
                if (q_inst.size() != 0) begin
                    void'(q_inst.pop_front()); void'(q_err.pop_front());
                    void'(q_imm.pop_front());  void'(q_op.pop_front());
                end
                got++;
            end
            if (fired) begin
                note_accept();
                accept_pos = got;
            end
            @(posedge clk); #1;
            if (fired) drive(1'b0, 3'd0, 32'h0, 32'h0);
        end
        n_tests++;
        if (got != 4) begin
            n_fail++; $display("FAIL bp_drain: got %0d outputs want 4", got);
        end
        n_tests++;
        if (accept_pos != 1) begin
            n_fail++; $display("FAIL bp_fourth_accept: accepted after %0d pops, want 1", accept_pos);
        end
        n_tests++;
        if (err_cnt !== 16'(m_err_cnt)) begin
            n_fail++; $display("FAIL bp_err_cnt: got %0d want %0d", err_cnt, m_err_cnt);
        end
    endtask

    task automatic test_streaming();
        logic [2:0]  op;
        logic [31:0] imm, base;
        int sent, got, cyc, stalls;
        bit fired;
        clear_model();
        m_err_cnt = err_cnt;
        bus.out_ready = 1'b1;
        sent = 0; got = 0; cyc = 0; stalls = 0;
        gen_req(op, imm, base);
        drive(1'b1, op, imm, base);
        while (got < 100 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) begin
                n_tests++;
                if (q_inst.size() == 0 || bus.out_inst !== q_inst[0] || bus.out_err !== q_err[0]) begin
                    n_fail++;
                    $display("FAIL stream_out%0d: got %h/%b want %h/%b", got, bus.out_inst, bus.out_err,
                             (q_inst.size() != 0) ? q_inst[0] : 32'h0, (q_err.size() != 0) ? q_err[0] : 1'b0);
                end else if (!q_err[0]) begin
                    n_tests++;
                    if (ref_decode(q_op[0], bus.out_inst) !== q_imm[0]) begin
                        n_fail++;
                        $display("FAIL stream_roundtrip%0d: decoded %h want %h", got,
                                 ref_decode(q_op[0], bus.out_inst), q_imm[0]);
                    end
                end
                if (q_inst.size() != 0) begin
                    void'(q_inst.pop_front()); void'(q_err.pop_front());
                    void'(q_imm.pop_front());  void'(q_op.pop_front());
                end
                got++;
            end
            fired = bus.in_valid && bus.in_ready;
            if (bus.in_valid && !bus.in_ready) stalls++;
            if (fired) begin
                note_accept();
                sent++;
            end
            @(posedge clk); #1;
            if (fired) begin
                if (sent < 100) begin
                    gen_req(op, imm, base);
                    drive(1'b1, op, imm, base);
                end else begin
                    drive(1'b0, 3'd0, 32'h0, 32'h0);
                end
            end
        end
        n_tests++;
        if (got != 100) begin
            n_fail++; $display("FAIL stream_count: got %0d outputs want 100", got);
        end
        n_tests++;
        if (stalls != 0 || cyc > 102) begin
            n_fail++; $display("FAIL stream_throughput: %0d stalls, %0d cycles, want 0 and <=102", stalls, cyc);
        end
        n_tests++;
        if (err_cnt !== 16'(m_err_cnt)) begin
            n_fail++; $display("FAIL stream_err_cnt: got %0d want %0d", err_cnt, m_err_cnt);
        end
    endtask

    task automatic test_reset_midop();
        int outs;
        bit fired;
        clear_model();
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 3'd6, 32'h1, 32'h13);
        @(posedge clk); #1;
        drive(1'b1, 3'd0, 32'h7, 32'h13);
        @(posedge clk); #1;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || err_cnt === 16'h0) begin
            n_fail++; $display("FAIL rst_preload: out_valid %b err_cnt %0d, want 1 and nonzero", bus.out_valid, err_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_out_valid: got %b want 0", bus.out_valid);
        end
        n_tests++;
        if (err_cnt !== 16'h0) begin
            n_fail++; $display("FAIL rst_async_err_cnt: got %0d want 0", err_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 3'd2, 32'h00000010, 32'h0000A023);
        outs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
            if (fired) note_accept();
            if (bus.out_valid) begin
                n_tests++;
                if (q_inst.size() == 0 || bus.out_inst !== q_inst[0] || bus.out_err !== q_err[0]) begin
                    n_fail++;
                    $display("FAIL rst_after_out%0d: got %h/%b want %h/%b", outs, bus.out_inst, bus.out_err,
                             (q_inst.size() != 0) ? q_inst[0] : 32'h0, (q_err.size() != 0) ? q_err[0] : 1'b0);
                end
                if (q_inst.size() != 0) begin
                    void'(q_inst.pop_front()); void'(q_err.pop_front());
                    void'(q_imm.pop_front());  void'(q_op.pop_front());
                end
                outs++;
            end
            @(posedge clk); #1;
            if (fired) drive(1'b0, 3'd0, 32'h0, 32'h0);
        end
        n_tests++;
        if (outs != 1) begin
            n_fail++; $display("FAIL rst_after_count: got %0d outputs want 1", outs);
        end
        n_tests++;
        if (err_cnt !== 16'(m_err_cnt)) begin
            n_fail++; $display("FAIL rst_after_err_cnt: got %0d want %0d", err_cnt, m_err_cnt);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_streaming();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
